noc_output_arbiter: RTL and testbench
=====================================

Name: noc_output_arbiter

Overview:
- Round-robin, packet-locked arbiter for one router output port.
- Shares the output link among the 5 input queues that target it. Each queue raises its req_port_addrN toward this port.
- On grant, it pops flits from the winning queue until the tail flit has passed, and drives the registered output link.
- A watchdog releases a lock whose owner stalls too long.

Parameters:
- NUM_PORTS, 5, number of requesting input queues.
- DATA_W, 16, flit width.
- TAIL_BIT, 15, flit bit index that marks the tail flit (1 = last flit of packet).
- TIMEOUT, 64, idle cycles allowed while locked before forced release. Must be ≥2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low.
- req_i  input  NUM_PORTS  per-queue request for this output port (req_port_addrN of each queue).
- valid_i  input  NUM_PORTS  per-queue head-flit valid (queue not empty).
- data_i  input  NUM_PORTS*DATA_W  head flits; queue k in bits [k*DATA_W +: DATA_W].
- out_ready_i  input  1  downstream can accept a flit this cycle.
- pop_o  output  NUM_PORTS  one-hot pop_req to the queues. Combinational.
- gnt_o  output  NUM_PORTS  one-hot current owner. Registered, all zero when idle.
- data_o  output  DATA_W  registered output flit.
- valid_o  output  1  data_o valid. Registered, one-cycle pulse per flit.
- timeout_o  output  1  one-cycle pulse when a lock is force-released.

Behaviour:
- Reset: applies when rst=0 at a clk edge.
  - gnt_o=0, data_o=0, valid_o=0, timeout_o=0, state=IDLE.
  - RR pointer ptr=0, watchdog count wcnt=0.
  - Reset mid-packet drops the lock with no tail required. The queue keeps its remaining flits.
- States: IDLE and LOCKED.
- IDLE:
  - pop_o=0.
  - If req_i≠0, winner = first set bit of req_i searched from ptr upward, wrapping modulo NUM_PORTS.
  - Next edge: gnt_o=onehot(winner), state=LOCKED, wcnt=0.
  - If req_i=0, remain IDLE.
  - Arbitration costs one cycle; the first pop happens no earlier than the cycle after the grant.
- LOCKED, owner g:
  - pop_o[g] = out_ready_i & valid_i[g]. All other pop_o bits are 0.
  - On a pop edge: data_o ← data_i[g], valid_o ← 1, wcnt ← 0.
  - On a non-pop edge: valid_o ← 0, wcnt ← wcnt+1.
  - Flit latency: pop cycle → data_o/valid_o one cycle later.
  - Lock holds even if req_i[g] deasserts; req_i is sampled only in IDLE.
- Tail:
  - If the popped flit has data_i[g][TAIL_BIT]=1, at that edge: state ← IDLE, gnt_o ← 0, ptr ← (g+1) mod NUM_PORTS.
  - A head flit that is also the tail (single-flit packet) releases after one pop.
  - After release, IDLE takes one cycle, so back-to-back packets have at least one bubble cycle on pop.
- Watchdog:
  - In LOCKED, if wcnt reaches TIMEOUT-1 and the current cycle has no pop, at that edge: state ← IDLE, gnt_o ← 0, ptr ← (g+1) mod NUM_PORTS, timeout_o ← 1 for one cycle.
  - A pop on the same cycle wins: the watchdog does not fire and wcnt ← 0.
- Simultaneous requests: resolved strictly by RR from ptr. Every requester is granted within NUM_PORTS packets.
- out_ready_i low: no pop, valid_o=0 next cycle, data_o holds its last value.
- valid_o never asserts in IDLE except for the registered tail flit in the first IDLE cycle.
- One-hot invariants, asserted in the bench:
  - $onehot0(gnt_o).
  - $onehot0(pop_o).
  - pop_o is a subset of gnt_o.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, req_i=5'b10110 → gnt_o=0, pop_o=0, valid_o=0 during reset. After rst=1: gnt_o=5'b00010 one cycle later (ptr=0, first set bit is 1).
- 3-flit packet from port 2:
  - Stimulus: req_i=5'b00100, valid_i[2]=1, out_ready_i=1, flits 16'h0A01, 16'h0A02, 16'h8A03.
  - Required: pop_o=5'b00100 for 3 consecutive cycles; data_o sequence 0A01, 0A02, 8A03 with valid_o=1, each one cycle after its pop; gnt_o=0 and ptr=3 after the tail.
- Round-robin fairness:
  - Stimulus: all 5 requesting continuously with single-flit packets (bit15=1).
  - Required: grant order 0,1,2,3,4,0; one pop every 2 cycles.
- Backpressure and lock hold:
  - Stimulus: owner port 1 mid-packet; out_ready_i=0 for 5 cycles; req_i[1] dropped; req_i[3]=1.
  - Required: pop_o=0 and valid_o=0 during the stall; gnt_o stays 5'b00010; pops resume on port 1 when out_ready_i=1.
- Watchdog (TIMEOUT=64):
  - Stimulus: owner port 4, valid_i[4]=0 for 64 cycles.
  - Required: timeout_o pulses once on the 64th non-pop cycle; gnt_o=0; next grant searches from ptr=0.
- Reset mid-packet: rst=0 while port 0 is locked after 1 of 3 flits → next cycle gnt_o=0, valid_o=0, ptr=0, no further pops.

Source files
------------

// File: rtl/noc_output_arbiter.sv
// Round-robin, packet-locked arbiter for one router output port.
// Grants one input queue, pops its flits through a registered link until the tail, with a stall watchdog.

module noc_arb_lane #(
  parameter int DATA_W = 16
) (
  input  logic              gnt,
  input  logic              valid,
  input  logic              ready,
  input  logic [DATA_W-1:0] data,
  output logic              pop,
  output logic [DATA_W-1:0] sel_data
);
  assign pop      = gnt & valid & ready;
  assign sel_data = pop ? data : '0;
endmodule

module noc_output_arbiter #(
  parameter int NUM_PORTS = 5,
  parameter int DATA_W    = 16,
  parameter int TAIL_BIT  = 15,
  parameter int TIMEOUT   = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req_i,
  input  logic [NUM_PORTS-1:0]        valid_i,
  input  logic [NUM_PORTS*DATA_W-1:0] data_i,
  input  logic                        out_ready_i,
  output logic [NUM_PORTS-1:0]        pop_o,
  output logic [NUM_PORTS-1:0]        gnt_o,
  output logic [DATA_W-1:0]           data_o,
  output logic                        valid_o,
  output logic                        timeout_o
);
  localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int WCW = $clog2(TIMEOUT);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                          state;
  logic [PW-1:0]                   ptr;
  logic [WCW-1:0]                  wcnt;
  logic [NUM_PORTS-1:0][DATA_W-1:0] lane_data;
  logic [DATA_W-1:0]               pop_data;
  logic                            pop_any;
  logic [PW-1:0]                   win_idx;
  logic [PW-1:0]                   own_idx;
  logic [PW-1:0]                   nxt_ptr;

  // gnt_o is all-zero outside LOCKED, so the lanes need no state qualifier.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
    noc_arb_lane #(.DATA_W(DATA_W)) u_lane (
      .gnt      (gnt_o[i]),
      .valid    (valid_i[i]),
      .ready    (out_ready_i),
      .data     (data_i[i*DATA_W +: DATA_W]),
      .pop      (pop_o[i]),
      .sel_data (lane_data[i])
    );
  end

  always_comb begin
    pop_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) pop_data = pop_data | lane_data[i];
  end

  assign pop_any = |pop_o;

  always_comb begin
    int   idx;
    logic found;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (int'(ptr) + i) % NUM_PORTS;
      if (!found && req_i[idx]) begin
        found   = 1'b1;
        win_idx = PW'(idx);
      end
    end
  end

  always_comb begin
    own_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (gnt_o[i]) own_idx = PW'(i);
  end

  assign nxt_ptr = (own_idx == PW'(NUM_PORTS-1)) ? '0 : own_idx + PW'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      gnt_o     <= '0;
      data_o    <= '0;
      valid_o   <= 1'b0;
      timeout_o <= 1'b0;
      ptr       <= '0;
      wcnt      <= '0;
    end else begin
      timeout_o <= 1'b0;
      valid_o   <= pop_any;
      if (pop_any) data_o <= pop_data;
      case (state)
        IDLE: begin
          if (|req_i) begin
            gnt_o <= NUM_PORTS'(1) << win_idx;
            state <= LOCKED;
            wcnt  <= '0;
          end
        end
        LOCKED: begin
          if (pop_any) begin
            wcnt <= '0;
            if (pop_data[TAIL_BIT]) begin
              state <= IDLE;
              gnt_o <= '0;
              ptr   <= nxt_ptr;
            end
          end else if (wcnt == WCW'(TIMEOUT-1)) begin
            // a stalled owner loses the link; a same-cycle pop takes priority above
            state     <= IDLE;
            gnt_o     <= '0;
            ptr       <= nxt_ptr;
            timeout_o <= 1'b1;
          end else begin
            wcnt <= wcnt + WCW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_noc_output_arbiter.sv
// Self-checking bench for noc_output_arbiter: directed scenarios plus random traffic
// compared against a packet-level reference model.

module tb_noc_output_arbiter;
  localparam int N  = 5;
  localparam int DW = 16;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, vld;
  logic [N*DW-1:0] din;
  logic            rdy;
  logic [N-1:0]    pop_o, gnt_o;
  logic [DW-1:0]   data_o;
  logic            valid_o, timeout_o;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_state = 0;  // 0 idle, 1 locked
  int          m_owner = 0;
  int          m_ptr   = 0;
  int          m_cnt   = 0;
  logic [N-1:0] m_gnt  = '0;
  logic [DW-1:0] m_data = '0;
  logic        m_valid = 1'b0;
  logic        m_to    = 1'b0;

  noc_output_arbiter #(.NUM_PORTS(N), .DATA_W(DW), .TAIL_BIT(15), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_i(req), .valid_i(vld), .data_i(din),
    .out_ready_i(rdy), .pop_o(pop_o), .gnt_o(gnt_o), .data_o(data_o),
    .valid_o(valid_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    checks++;
    if (!$onehot0(gnt_o) || !$onehot0(pop_o) || ((pop_o & ~gnt_o) != '0)) begin
      errors++;
      $display("FAIL onehot_invariant gnt=%b pop=%b", gnt_o, pop_o);
    end
  end

  function automatic logic [N-1:0] m_pop();
    if (m_state == 1 && rdy && vld[m_owner]) return N'(1) << m_owner;
    return '0;
  endfunction

  function automatic int m_winner();
    for (int i = 0; i < N; i++)
      if (req[(m_ptr + i) % N]) return (m_ptr + i) % N;
    return -1;
  endfunction

  task automatic set_flit(input int k, input logic [DW-1:0] f);
    din[k*DW +: DW] = f;
  endtask

  // advance one clock and step the model with the inputs present before the edge
  task automatic tick();
    logic [N-1:0]  p;
    logic [DW-1:0] f;
    int            w;
    p = m_pop();
    f = din[m_owner*DW +: DW];
    w = m_winner();
    @(posedge clk);
    if (!rst) begin
      m_state = 0; m_gnt = '0; m_data = '0; m_valid = 0; m_to = 0; m_ptr = 0; m_cnt = 0;
    end else begin
      m_to    = 0;
      m_valid = (p != '0);
      if (p != '0) m_data = f;
      if (m_state == 0) begin
        if (w >= 0) begin m_owner = w; m_gnt = N'(1) << w; m_state = 1; m_cnt = 0; end
      end else if (p != '0) begin
        m_cnt = 0;
        if (f[15]) begin m_state = 0; m_gnt = '0; m_ptr = (m_owner + 1) % N; end
      end else if (m_cnt == TO - 1) begin
        m_state = 0; m_gnt = '0; m_ptr = (m_owner + 1) % N; m_to = 1;
      end else begin
        m_cnt++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 0; req = '0; vld = '0; din = '0; rdy = 1;
    tick(); tick();
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0; req = 5'b10110; vld = '0; din = '0; rdy = 1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (gnt_o !== '0 || pop_o !== '0 || valid_o !== 1'b0 || timeout_o !== 1'b0 || data_o !== '0) begin
        errors++;
        $display("FAIL reset_state gnt=%b pop=%b valid=%b to=%b data=%h want all zero",
                 gnt_o, pop_o, valid_o, timeout_o, data_o);
      end
    end
    rst = 1;
    tick();
    checks++;
    if (gnt_o !== 5'b00010) begin
      errors++;
      $display("FAIL reset_first_grant gnt=%b want 00010", gnt_o);
    end
  endtask

  task automatic test_packet();
    logic [DW-1:0] fl [3];
    fl[0] = 16'h0A01; fl[1] = 16'h0A02; fl[2] = 16'h8A03;
    do_reset();
    req = 5'b00100; vld = 5'b00100; set_flit(2, fl[0]);
    #1;
    checks++;
    if (pop_o !== '0) begin errors++; $display("FAIL pkt_no_pop_idle pop=%b want 00000", pop_o); end
    tick();
    for (int i = 0; i < 3; i++) begin
      set_flit(2, fl[i]);
      #1;
      checks++;
      if (pop_o !== 5'b00100) begin errors++; $display("FAIL pkt_pop[%0d] pop=%b want 00100", i, pop_o); end
      tick();
      checks++;
      if (data_o !== fl[i] || valid_o !== 1'b1 || gnt_o !== ((i < 2) ? 5'b00100 : 5'b00000)) begin
        errors++;
        $display("FAIL pkt_out[%0d] data=%h valid=%b gnt=%b want %h 1 %b", i, data_o, valid_o, gnt_o,
                 fl[i], (i < 2) ? 5'b00100 : 5'b00000);
      end
    end
    // ptr is now 3: with ports 2 and 3 requesting, 3 must win
    req = 5'b01100; vld = '0;
    tick();
    checks++;
    if (gnt_o !== 5'b01000 || valid_o !== 1'b0) begin
      errors++; $display("FAIL pkt_ptr_after_tail gnt=%b valid=%b want 01000 0", gnt_o, valid_o);
    end
  endtask

  task automatic test_rr();
    int order [6];
    order = '{0, 1, 2, 3, 4, 0};
    do_reset();
    req = '1; vld = '1;
    for (int k = 0; k < N; k++) set_flit(k, 16'h8000 | DW'(k + 16'h10));
    for (int c = 0; c < 12; c++) begin
      #1;
      checks++;
      if ((c % 2 == 1 && pop_o !== (N'(1) << order[c/2])) || (c % 2 == 0 && pop_o !== '0)) begin
        errors++; $display("FAIL rr_pop cycle=%0d pop=%b want %b", c, pop_o,
                           (c % 2 == 1) ? (N'(1) << order[c/2]) : N'(0));
      end
      tick();
      checks++;
      if (gnt_o !== m_gnt || valid_o !== m_valid || data_o !== m_data) begin
        errors++; $display("FAIL rr_model cycle=%0d gnt=%b valid=%b data=%h want %b %b %h",
                           c, gnt_o, valid_o, data_o, m_gnt, m_valid, m_data);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 5'b00010; vld = 5'b00010; set_flit(1, 16'h0B01);
    tick();
    #1;
    checks++;
    if (pop_o !== 5'b00010) begin errors++; $display("FAIL bp_first_pop pop=%b want 00010", pop_o); end
    tick();
    rdy = 0; req = 5'b01000; set_flit(1, 16'h8B02);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (pop_o !== '0) begin errors++; $display("FAIL bp_stall_pop cycle=%0d pop=%b want 00000", c, pop_o); end
      tick();
      checks++;
      if (valid_o !== 1'b0 || gnt_o !== 5'b00010 || data_o !== 16'h0B01) begin
        errors++; $display("FAIL bp_stall_out cycle=%0d valid=%b gnt=%b data=%h want 0 00010 0b01",
                           c, valid_o, gnt_o, data_o);
      end
    end
    rdy = 1;
    #1;
    checks++;
    if (pop_o !== 5'b00010) begin errors++; $display("FAIL bp_resume_pop pop=%b want 00010", pop_o); end
    tick();
    checks++;
    if (data_o !== 16'h8B02 || valid_o !== 1'b1 || gnt_o !== '0) begin
      errors++; $display("FAIL bp_resume_out data=%h valid=%b gnt=%b want 8b02 1 00000", data_o, valid_o, gnt_o);
    end
  endtask

  task automatic test_watchdog();
    int pulses = 0;
    do_reset();
    req = 5'b10000; vld = '0;
    tick();
    req = '0;
    for (int i = 1; i <= TO; i++) begin
      tick();
      if (timeout_o) pulses++;
      checks++;
      if (timeout_o !== (i == TO) || gnt_o !== ((i == TO) ? 5'b00000 : 5'b10000)) begin
        errors++; $display("FAIL wd_cycle[%0d] to=%b gnt=%b want %b %b", i, timeout_o, gnt_o,
                           (i == TO), (i == TO) ? 5'b00000 : 5'b10000);
      end
    end
    req = 5'b10001;
    tick();
    if (timeout_o) pulses++;
    checks++;
    if (pulses != 1 || timeout_o !== 1'b0 || gnt_o !== 5'b00001) begin
      errors++; $display("FAIL wd_release pulses=%0d to=%b gnt=%b want 1 0 00001", pulses, timeout_o, gnt_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 5'b00001; vld = 5'b00001; set_flit(0, 16'h0C01);
    tick();
    tick();
    checks++;
    if (valid_o !== 1'b1 || data_o !== 16'h0C01) begin
      errors++; $display("FAIL rm_first_flit valid=%b data=%h want 1 0c01", valid_o, data_o);
    end
    set_flit(0, 16'h0C02);
    rst = 0;
    tick();
    checks++;
    if (gnt_o !== '0 || valid_o !== 1'b0 || data_o !== '0) begin
      errors++; $display("FAIL rm_reset gnt=%b valid=%b data=%h want 00000 0 0000", gnt_o, valid_o, data_o);
    end
    rst = 1; req = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (pop_o !== '0 || gnt_o !== '0) begin
        errors++; $display("FAIL rm_no_pop cycle=%0d pop=%b gnt=%b want 0 0", c, pop_o, gnt_o);
      end
      tick();
    end
    req = 5'b00110;
    tick();
    checks++;
    if (gnt_o !== 5'b00010) begin errors++; $display("FAIL rm_ptr_zero gnt=%b want 00010", gnt_o); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 199) != 0);
      req = N'($urandom);
      vld = N'($urandom) | N'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++)
        set_flit(k, {($urandom_range(0, 2) == 0), 15'($urandom)});
      #1;
      checks++;
      if (pop_o !== m_pop()) begin
        errors++; $display("FAIL rand_pop cycle=%0d pop=%b want %b", c, pop_o, m_pop());
      end
      tick();
      checks++;
      if (gnt_o !== m_gnt || valid_o !== m_valid || data_o !== m_data || timeout_o !== m_to) begin
        errors++; $display("FAIL rand_out cycle=%0d gnt=%b valid=%b data=%h to=%b want %b %b %h %b",
                           c, gnt_o, valid_o, data_o, timeout_o, m_gnt, m_valid, m_data, m_to);
      end
    end
    // long stall stretch so the watchdog also fires against the model
    rst = 1; req = 5'b01000; vld = '0; rdy = 1;
    for (int c = 0; c < TO + 8; c++) begin
      tick();
      req = '0;
      checks++;
      if (gnt_o !== m_gnt || timeout_o !== m_to || valid_o !== m_valid) begin
        errors++; $display("FAIL rand_wd cycle=%0d gnt=%b to=%b valid=%b want %b %b %b",
                           c, gnt_o, timeout_o, valid_o, m_gnt, m_to, m_valid);
      end
    end
  endtask

  initial begin
    rst = 0; req = '0; vld = '0; din = '0; rdy = 1;
    test_reset();
    test_packet();
    test_rr();
    test_backpressure();
    test_watchdog();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
